// File: rtl/fir_serial_mc.sv
// Multi-channel time-multiplexed serial FIR filter.
// One shared MAC, per-channel circular delay lines, runtime-loadable coefficients.
module fir_serial_mc #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEFF_W   = 16,
  parameter int unsigned TAPS      = 64,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned OUT_SHIFT = 15,
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned TAP_W    = $clog2(TAPS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_enable,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH_W-1:0]    in_channel,
  input  logic [DATA_W-1:0]  filter_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH_W-1:0]    out_channel,
  output logic [DATA_W-1:0]  filter_out,
  output logic               sat_flag,
  input  logic               coeff_we,
  input  logic [TAP_W-1:0]   coeff_addr,
  input  logic [COEFF_W-1:0] coeff_wdata,
  output logic               coeff_drop
);

  localparam int unsigned PROD_W = DATA_W + COEFF_W;
  localparam int unsigned ACC_W  = DATA_W + COEFF_W + TAP_W;
  localparam int unsigned DL_W   = CH_W + TAP_W;
  localparam int unsigned DL_N   = CHANNELS * TAPS;

  localparam logic [DL_W-1:0]         CLR_LAST = DL_W'(DL_N - 1);
  localparam logic [TAP_W-1:0]        TAP_LAST = TAP_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] RND_K    = ACC_W'(1) << (OUT_SHIFT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

  localparam logic [2:0] ST_CLEAR = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_MAC   = 3'd2;
  localparam logic [2:0] ST_ROUND = 3'd3;
  localparam logic [2:0] ST_OUT   = 3'd4;

  logic signed [DATA_W-1:0]  dl_mem [DL_N];
  logic signed [COEFF_W-1:0] cf_mem [TAPS];
  logic [TAP_W-1:0]          ptr_q  [CHANNELS];

  logic [2:0]               state_q, state_d;
  logic [DL_W-1:0]          clr_q, clr_d;
  logic [TAP_W-1:0]         tap_q, tap_d;
  logic [TAP_W-1:0]         base_q, base_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]        fout_q, fout_d;
  logic [CH_W-1:0]          och_q, och_d;
  logic                     sat_q, sat_d;
  logic                     drop_q, drop_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;

  logic                      dl_we_c;
  logic [DL_W-1:0]           dl_waddr_c;
  logic signed [DATA_W-1:0]  dl_wdata_c;
  logic                      cf_we_c;
  logic [TAP_W-1:0]          cf_waddr_c;
  logic signed [COEFF_W-1:0] cf_wdata_c;
  logic                      ptr_we_c;
  logic                      ch_ok_c;
  logic [DL_W-1:0]           dl_raddr_c;
  logic signed [DATA_W-1:0]  dl_rd_c;
  logic signed [COEFF_W-1:0] cf_rd_c;
  logic signed [PROD_W-1:0]  prod_c;
  logic signed [ACC_W-1:0]   rnd_c;
  logic signed [ACC_W-1:0]   shr_c;

  // Tap k reads the sample k positions older than the newest one of the latched channel.
  assign dl_raddr_c = {ch_q, base_q - tap_q};
  assign dl_rd_c    = dl_mem[dl_raddr_c];
  assign cf_rd_c    = cf_mem[tap_q];
  assign prod_c     = PROD_W'(dl_rd_c) * PROD_W'(cf_rd_c);
  assign rnd_c      = acc_q + RND_K;
  assign shr_c      = rnd_c >>> OUT_SHIFT;
  assign ch_ok_c    = (32'(in_channel) < CHANNELS);

  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    tap_d      = tap_q;
    base_d     = base_q;
    ch_d       = ch_q;
    acc_d      = acc_q;
    fout_d     = fout_q;
    och_d      = och_q;
    sat_d      = sat_q;
    drop_d     = coeff_we && (state_q != ST_IDLE);
    dl_we_c    = 1'b0;
    dl_waddr_c = '0;
    dl_wdata_c = '0;
    cf_we_c    = 1'b0;
    cf_waddr_c = '0;
    cf_wdata_c = '0;
    ptr_we_c   = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        dl_we_c    = 1'b1;
        dl_waddr_c = clr_q;
        cf_we_c    = 1'b1;
        cf_waddr_c = clr_q[TAP_W-1:0];
        if (clr_q == CLR_LAST) begin
          state_d = ST_IDLE;
        end else begin
          clr_d = clr_q + DL_W'(1);
        end
      end
      ST_IDLE: begin
        if (coeff_we) begin
          cf_we_c    = 1'b1;
          cf_waddr_c = coeff_addr;
          cf_wdata_c = coeff_wdata;
        end
        // Samples tagged with a non-existent channel are consumed and dropped.
        if (in_valid && ch_ok_c) begin
          dl_we_c    = 1'b1;
          dl_waddr_c = {in_channel, ptr_q[in_channel]};
          dl_wdata_c = filter_in;
          ptr_we_c   = 1'b1;
          base_d     = ptr_q[in_channel];
          ch_d       = in_channel;
          acc_d      = '0;
          tap_d      = '0;
          state_d    = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + {{TAP_W{prod_c[PROD_W-1]}}, prod_c};
        tap_d = tap_q + TAP_W'(1);
        if (tap_q == TAP_LAST) begin
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        och_d = ch_q;
        if (shr_c > SAT_MAX) begin
          fout_d = SAT_MAX[DATA_W-1:0];
          sat_d  = 1'b1;
        end else if (shr_c < SAT_MIN) begin
          fout_d = SAT_MIN[DATA_W-1:0];
          sat_d  = 1'b1;
        end else begin
          fout_d = shr_c[DATA_W-1:0];
          sat_d  = 1'b0;
        end
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_q       <= '0;
      tap_q       <= '0;
      base_q      <= '0;
      ch_q        <= '0;
      acc_q       <= '0;
      fout_q      <= '0;
      och_q       <= '0;
      sat_q       <= 1'b0;
      drop_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clk_enable) begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      tap_q       <= tap_d;
      base_q      <= base_d;
      ch_q        <= ch_d;
      acc_q       <= acc_d;
      fout_q      <= fout_d;
      och_q       <= och_d;
      sat_q       <= sat_d;
      drop_q      <= drop_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) ptr_q[i] <= '0;
    end else if (clk_enable) begin
      if (state_q == ST_CLEAR) begin
        for (int unsigned i = 0; i < CHANNELS; i++) ptr_q[i] <= '0;
      end else if (ptr_we_c) begin
        ptr_q[in_channel] <= ptr_q[in_channel] + TAP_W'(1);
      end
    end
  end

  // Storage arrays carry no reset; CLEAR walks and zeroes them.
  always_ff @(posedge clk) begin
    if (!rst && clk_enable) begin
      if (dl_we_c) dl_mem[dl_waddr_c] <= dl_wdata_c;
      if (cf_we_c) cf_mem[cf_waddr_c] <= cf_wdata_c;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_channel = och_q;
  assign filter_out  = fout_q;
  assign sat_flag    = sat_q;
  assign coeff_drop  = drop_q;

endmodule

// File: doc/fir_serial_mc.md
Name: fir_serial_mc

Overview:
- Parametrised, multi-channel, time-multiplexed serial FIR filter for the audio equalizer datapath; successor to the fixed 16-bit single-channel serial filter.
- One shared MAC serves CHANNELS independent delay lines, each holding TAPS samples.
- Samples enter and results leave through valid/ready handshakes. Coefficients are runtime-loadable instead of fixed ROM.
- Sits between the audio sample source (per-channel tagged samples) and the band summing/gain stage.

Parameters:
- DATA_W, 16, sample width in/out (signed two's complement).
- COEFF_W, 16, coefficient width (signed, Q1.(COEFF_W-1)).
- TAPS, 64, filter length per channel; power of two, 4..256.
- CHANNELS, 2, number of independent channels, 1..8.
- OUT_SHIFT, 15, right shift applied to accumulator before saturation; 1..COEFF_W+4.
- Derived, not overridable:
  - CH_W = max(1, clog2(CHANNELS))
  - TAP_W = clog2(TAPS)
  - ACC_W = DATA_W + COEFF_W + TAP_W

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- clk_enable, in, 1, global advance enable; when 0 all state, outputs and handshakes freeze.
- in_valid, in, 1, filter_in/in_channel valid.
- in_ready, out, 1, block accepts a sample; high only in IDLE.
- in_channel, in, CH_W, channel tag of input sample.
- filter_in, in, DATA_W, signed input sample.
- out_valid, out, 1, filter_out/out_channel valid.
- out_ready, in, 1, downstream accepts result.
- out_channel, out, CH_W, channel tag of result.
- filter_out, out, DATA_W, signed filtered sample.
- sat_flag, out, 1, result was saturated; valid with out_valid.
- coeff_we, in, 1, coefficient write strobe.
- coeff_addr, in, TAP_W, tap index k.
- coeff_wdata, in, COEFF_W, coefficient value c[k].
- coeff_drop, out, 1, one-cycle pulse: a coeff write was rejected.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- All register updates and handshakes qualify on clk_enable=1. A transfer occurs on an edge where clk_enable=1 and valid&ready.
- Function: y[n] = sat(round(sum_{k=0}^{TAPS-1} c[k]·x[n-k]) >> OUT_SHIFT), computed per channel. c[0] multiplies the newest sample. Coefficients are shared by all channels.
- FSM states: CLEAR, IDLE, MAC, ROUND, OUT.
- rst (also mid-operation) forces CLEAR:
  - in_ready=0, out_valid=0, filter_out=0, out_channel=0, sat_flag=0, coeff_drop=0.
  - Any in-flight computation is discarded.
- CLEAR walks max(CHANNELS·TAPS, TAPS) enabled cycles. It zeroes all delay-line entries, all coefficients and all channel write pointers, then enters IDLE.
- IDLE: in_ready=1. On an input transfer:
  - Write filter_in at the channel's circular pointer; advance the pointer mod TAPS (wraps TAPS-1 -> 0).
  - Latch in_channel, clear the accumulator, go to MAC.
- MAC: exactly TAPS enabled cycles, tap k on cycle k.
  - acc += x[ptr-k] · c[k]; full-precision product, sign-extended to ACC_W; no overflow possible.
- ROUND: 1 cycle.
  - Compute t = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT.
  - Saturate t to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and register it into filter_out.
  - sat_flag=1 if clipped. out_channel = latched tag. Then OUT.
- OUT: out_valid=1; filter_out/out_channel/sat_flag held stable until the output transfer, then IDLE.
- Latency: input accepted at edge 0 -> out_valid visible after enabled edge TAPS+1. Minimum input spacing is TAPS+3 enabled cycles with out_ready tied high.
- Backpressure: while in OUT with out_ready=0, in_ready stays 0 and nothing is lost.
- Coefficient writes:
  - Accepted only when state=IDLE and clk_enable=1. Take effect for the next accepted sample.
  - In any other state the write is ignored and coeff_drop pulses for one enabled cycle.
  - A write and an input transfer on the same IDLE edge: the write is applied first, so the new coefficient is used for that sample.
- in_channel >= CHANNELS: sample is accepted and discarded (no delay-line write, no output); FSM stays IDLE.
- clk_enable=0 mid-MAC: accumulator, tap index and state hold. Resuming yields a result identical to an uninterrupted run.

Test Plan:
- Impulse response: TAPS=64, CHANNELS=2, c[k]=256·k; ch0 input 0x4000 then 64 zeros -> ch0 outputs 0,128,256,…,8064; first out_valid after enabled edge 65 following acceptance.
- Channel isolation: interleave ch0 impulse 0x4000 with ch1 constant 0 -> all ch1 outputs 0, ch0 sequence unchanged; out_channel matches each input tag.
- Saturation/rounding: all c[k]=0x7FFF, input 0x7FFF repeated 64 times -> filter_out=0x7FFF, sat_flag=1. With only c[0]=1 and input 0x4000 -> (16384+16384)>>15 = 1, sat_flag=0.
- Backpressure and coeff drop: hold out_ready=0 for 20 cycles in OUT -> filter_out stable, in_ready=0. A coeff_we during MAC -> coeff_drop pulses once and output is unchanged.
- Reset mid-MAC: assert rst at MAC cycle 30 -> next cycle out_valid=0, in_ready=0 for CHANNELS·TAPS=128 enabled cycles; a subsequent impulse with unwritten coefficients -> outputs all 0.
- clk_enable gating: toggle clk_enable 50% pseudo-random during the impulse test -> identical output sequence, latency counted in enabled cycles only.
